bus_arbiter_rr: RTL
===================

// Module: bus_arbiter_rr
// PURPOSE
//   Round-robin arbiter for a shared 32-bit tristate bus. Consumes level requests
//   from NUM_REQ masters and produces a registered one-hot grant. Each grant bit
//   drives one tristate's oe. grant_idx drives the select of a mux8 when a muxed
//   readback of the owner is needed.
//   Guarantees: at most one driver at a time, dead cycles between owners, and a hold timeout.
// PARAMETERS
//   NUM_REQ     8   number of requesters (power of 2, 2..32)
//   IDX_W       3   log2(NUM_REQ)
//   MAX_HOLD    16  max consecutive grant cycles per ownership; 0 = unlimited
//   TURNAROUND  1   dead cycles (grant==0) between owners; 0 = direct handoff
// PORTS
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   req        in   NUM_REQ  level request per master
//   done       in   NUM_REQ  owner's end-of-transfer strobe; ignored from non-owners
//   grant      out  NUM_REQ  one-hot (or zero) tristate oe vector, registered
//   grant_idx  out  IDX_W    encoded owner; 0 when no owner
//   busy       out  1        1 while in OWN
//   timeout    out  1        1-cycle pulse on forced release
// BEHAVIOUR
//   Reset: state=IDLE, ptr=0, hold_cnt=0, gap_cnt=0.
//     grant=0, grant_idx=0, busy=0, timeout=0 immediately (async), no clock needed.
//   Arbitration (pick):
//     winner = first set req bit scanning ptr, ptr+1, ... mod NUM_REQ.
//     ptr = last owner + 1 mod NUM_REQ, updated on every release.
//   IDLE: when |req at a clock edge, grant/grant_idx/busy are asserted after that edge.
//     Latency is 1 cycle; go to OWN with hold_cnt=0.
//   OWN: grant is held constant. Release on the edge where the owner (index o) has any of:
//     (a) done[o]=1
//     (b) req[o]=0
//     (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, i.e. the owner has held MAX_HOLD cycles
//   On release:
//     ptr=o+1; grant=0, grant_idx=0, busy=0 next cycle.
//     If TURNAROUND>0: go to GAP with gap_cnt=0.
//     If TURNAROUND==0: pick immediately. The new one-hot grant replaces the old on
//       the same edge; if none pending, go to IDLE.
//     Otherwise hold_cnt increments.
//   timeout=1 for the one cycle following a release caused only by (c).
//     If (a) or (b) coincides with (c), the release is normal and timeout stays 0.
//   GAP: grant=0 for exactly TURNAROUND cycles.
//     On the last GAP cycle: if |req, pick and go to OWN (grant asserted next edge); else go to IDLE.
//     A requester that was just released may win again if it is the only requester.
//   Invariants:
//     $onehot0(grant) always.
//     grant_idx matches grant when busy.
//     busy == (grant != 0).
//   Requests arriving mid-OWN have no effect until release. Changes on done/req of non-owners are ignored.
//   Reset mid-OWN or mid-GAP aborts: outputs drop asynchronously, ptr returns to 0.
// TESTING
//   1. NUM_REQ=8, TURNAROUND=1, req=8'b0000_0101 after reset -> next edge grant=8'h01, idx=0, busy=1.
//      Pulse done[0] -> one cycle grant=0, then grant=8'h04, idx=2.
//   2. req=8'hFF held, each owner pulses done on its 2nd grant cycle ->
//      grants 01,02,04,...,80,01 in order, each separated by exactly one zero cycle.
//   3. MAX_HOLD=16, only req[3] held, no done -> grant=8'h08 for exactly 16 cycles.
//      Then grant=0 with timeout=1 for 1 cycle, then grant=8'h08 again.
//   4. Owner 2 active: done[2] and timeout condition on the same edge -> release with timeout=0.
//      done[5] pulsed while owner=2 -> no effect.
//   5. Assert reset mid-OWN between clock edges -> grant/busy/idx go to 0 before the next edge.
//      After deassert with req=8'h80 -> grant=8'h80 one edge later, because ptr was reset to 0.
//   6. TURNAROUND=0, req=8'h03, done[0] -> grant goes 01->02 on one edge, with no zero cycle.
//      Random req/done for 10k cycles -> $onehot0(grant) never violated.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the masters and the round-robin bus arbiter.
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned IDX_W   = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a shared tristate bus: registered one-hot grant,
// optional dead cycles between owners and an optional per-ownership hold limit.
module bus_arbiter_rr #(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input logic             clock,
  input logic             reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned GapW  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   pick_base;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               owner_done, owner_drop, hold_hit, release_own;

  // With direct handoff the scan must start past the owner being released this edge.
  assign pick_base = (state_q == StOwn) ? idx_q + IDX_W'(1) : ptr_q;

  // Rotating priority scan: first set request at or after pick_base (index wraps).
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = pick_base + IDX_W'(i);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

  assign owner_done  = bus.done[idx_q];
  assign owner_drop  = !bus.req[idx_q];
  assign hold_hit    = (MAX_HOLD != 0) && (hold_q == HoldW'(MAX_HOLD - 1));
  assign release_own = owner_done || owner_drop || hold_hit;

  // Next-state and next-grant decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StOwn;
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      StOwn: begin
        if (release_own) begin
          ptr_d     = idx_q + IDX_W'(1);
          // Forced release is flagged only when the owner had not ended on its own.
          timeout_d = hold_hit && !owner_done && !owner_drop;
          grant_d   = '0;
          idx_d     = '0;
          hold_d    = '0;
          if (TURNAROUND != 0) begin
            state_d = StGap;
            gap_d   = '0;
          end else if (pick_vld) begin
            state_d = StOwn;
            grant_d = pick_onehot;
            idx_d   = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(TURNAROUND - 1)) begin
          if (pick_vld) begin
            state_d = StOwn;
            grant_d = pick_onehot;
            idx_d   = pick_idx;
            hold_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset drops the grant without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = |grant_q;
  assign bus.timeout   = timeout_q;

endmodule
